anc_nlms_seq: RTL and testbench
===============================

# anc_nlms_seq

Serialized NLMS adaptive noise canceller that time-shares one multiplier across all filter taps under a sample-level valid/ready handshake. It replaces the fully parallel per-sample datapath wherever the sample rate is far below `clk`. The block sequences three phases per sample: delay-line shift, tap-by-tap FIR accumulation, then tap-by-tap coefficient update. It sits between the reference/noisy sample sources and the cleaned-output sink.

## Interface
- `DAT_LEN`, 16, sample width (signed)
- `COEFF_LEN`, 32, coefficient width (signed)
- `TAP_LEN`, 32, number of taps (≥2)
- `MU`, 4096, step size (signed 16-bit)
- `NOISE_SCLE`, 16384, output noise scale (signed 16-bit, Q15)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `in_valid`  in  1  sample pair valid
- `in_ready`  out  1  block can accept a sample
- `noise_in`  in  DAT_LEN  reference noise sample
- `desired_in`  in  DAT_LEN  noisy signal sample
- `adapt_en`  in  1  enable coefficient update; sampled at accept
- `out_valid`  out  1  `cleaned_out` valid
- `out_ready`  in  1  sink accepts output
- `cleaned_out`  out  DAT_LEN  cleaned sample
- `busy`  out  1  high in any state other than IDLE

## Operation
- Registers:
  - `coeff[0:TAP_LEN-1]`, COEFF_LEN each
  - `delay[0:TAP_LEN-1]`, DAT_LEN each
  - `acc`, COEFF_LEN+DAT_LEN+7 bits
  - `y`, `err`, `d_hold`, each DAT_LEN
  - `adapt_hold`, 1 bit
  - `tap_idx`, $clog2(TAP_LEN) bits
- FSM states: IDLE, FILTER, ERROR, UPDATE, OUT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: shift `delay[k]<=delay[k-1]` and `delay[0]<=noise_in`.
  - Capture `d_hold<=desired_in` and `adapt_hold<=adapt_en`.
  - Clear `acc` and `tap_idx`, then go to FILTER.
- FILTER: one tap per cycle, `acc += coeff[tap_idx]*delay[tap_idx]` (signed, full width). After tap TAP_LEN-1, go to ERROR.
- ERROR (1 cycle):
  - `y = acc>>>12`, truncated to DAT_LEN.
  - `err = d_hold - y`, truncated to DAT_LEN.
  - `cleaned = d_hold - ((y*NOISE_SCLE)>>>15)`.
  - Register `cleaned` into the output holding register.
  - Go to UPDATE if `adapt_hold`, else go to OUT.
- UPDATE: one tap per cycle.
  - `p = (MU*err*delay[tap_idx])>>>15`, computed in 64 bits.
  - `coeff[tap_idx] += p[COEFF_LEN-1:0]`, with wrap-around modulo 2^COEFF_LEN.
  - After tap TAP_LEN-1, go to OUT.
- OUT: `out_valid`=1 and `cleaned_out` is stable. When `out_ready` is high, return to IDLE.
- One multiplier-path product is used per cycle. FILTER and UPDATE never overlap.
- `in_valid` outside IDLE is ignored; `in_ready` is 0 there. There is no input buffering.
- `adapt_en` changes mid-sample have no effect until the next accept.
- Backpressure: while in OUT with `out_ready`=0, the state and all registers hold indefinitely.

## Timing
- Accept edge = cycle 0.
- FILTER occupies cycles 1..TAP_LEN.
- ERROR is cycle TAP_LEN+1.
- `out_valid` rises:
  - at cycle 2·TAP_LEN+2 when adapting;
  - at cycle TAP_LEN+2 when `adapt_hold`=0.
- With `out_ready`=1, `in_ready` returns 1 on the cycle after the OUT handshake. Throughput is 1 sample per 2·TAP_LEN+3 cycles.
- The new `coeff` values are visible to the next sample's FILTER.
- Reset values:
  - `in_ready`=0 during `rst`, 1 on the first cycle after release.
  - `out_valid`=0, `cleaned_out`=0, `busy`=0.
  - All `coeff`, `delay`, `acc`, `y`, `err` = 0; state IDLE.
- Reset mid-operation (any state) aborts the sample. The partial coefficient update is discarded by zeroing all coefficients, and no output is produced.

## Configuration
- `ANC_SAT_EN` defined:
  - `y`, `err` and `cleaned` saturate to [-2^(DAT_LEN-1), 2^(DAT_LEN-1)-1].
  - `coeff` updates saturate to the COEFF_LEN signed range.
- `ANC_SAT_EN` undefined: all of these truncate (two's-complement wrap). This matches the existing parallel canceller's numeric behaviour bit-exactly.

## Test plan
- After reset, with defaults, accept noise=500, desired=1000 → `cleaned_out`=1000 and `out_valid` at cycle 66. Afterwards `coeff[0]`=62500 and all other coefficients are 0.
- Follow with noise=500, desired=1000:
  - y=7629;
  - `cleaned_out`=1000−3814=−2814.
- Same two samples but with the second desired=−32000:
  - with `ANC_SAT_EN`, `cleaned_out`=−32768;
  - without it, `cleaned_out`=29722.
- `adapt_en`=0 on a sample → `out_valid` at cycle 34 and all coeff unchanged. `adapt_en` toggled mid-sample → no effect.
- Hold `out_ready`=0 for 10 cycles in OUT:
  - `cleaned_out` is stable and `in_ready`=0;
  - a `noise_in` pulse with `in_valid` is not accepted and the delay line is unchanged.
- Assert `rst` at cycle 40 of a sample → all outputs go to reset values immediately. The next sample behaves as in the first scenario (`cleaned_out`=1000).

Source files
------------

// File: rtl/anc_nlms_seq.sv
// anc_nlms_seq: serialized NLMS adaptive noise canceller.
// A single shared multiplier walks the taps twice per sample: once for the
// FIR sum (coeff*delay), and once for the coefficient update
// ((MU*err)*delay). A sample pair is taken in through a valid/ready handshake.
// The cleaned sample is held on the output until the sink takes it.
// Build option: define ANC_SAT_EN to saturate y/err/cleaned and the
// coefficient updates. Left undefined, everything wraps in two's complement.
module anc_nlms_seq #(
    parameter int                 DAT_LEN    = 16,
    parameter int                 COEFF_LEN  = 32,
    parameter int                 TAP_LEN    = 32,
    parameter logic signed [15:0] MU         = 16'sd4096,
    parameter logic signed [15:0] NOISE_SCLE = 16'sd16384
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DAT_LEN-1:0] noise_in,
    input  logic signed [DAT_LEN-1:0] desired_in,
    input  logic                      adapt_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DAT_LEN-1:0] cleaned_out,
    output logic                      busy
);
    localparam int IDX_W = $clog2(TAP_LEN);
    localparam int ACC_W = COEFF_LEN + DAT_LEN + 7;
    // Operand A carries either a coefficient or MU*err, so it is sized for the wider of the two.
    localparam int OPA_W = (COEFF_LEN > 16 + DAT_LEN) ? COEFF_LEN : 16 + DAT_LEN;
    localparam int PRD_W = OPA_W + DAT_LEN;
    localparam int YS_W  = DAT_LEN + 16;
    localparam int CL_W  = YS_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_FILTER, S_ERROR, S_UPDATE, S_OUT} state_t;

    state_t                      r_state, w_state_nxt;
    logic signed [COEFF_LEN-1:0] r_coeff [TAP_LEN];
    logic signed [DAT_LEN-1:0]   r_delay [TAP_LEN];
    logic signed [ACC_W-1:0]     r_acc;
    logic signed [DAT_LEN-1:0]   r_err, r_d_hold, r_cleaned;
    logic                        r_adapt_hold;
    logic [IDX_W-1:0]            r_tap_idx;

    logic                        w_last_tap;
    logic signed [OPA_W-1:0]     w_mu_err, w_opa;
    logic signed [PRD_W-1:0]     w_prod;
    logic signed [YS_W-1:0]      w_ys;
    logic signed [DAT_LEN-1:0]   w_y, w_err, w_cleaned;
    logic signed [COEFF_LEN-1:0] w_coeff_new;

    assign w_last_tap = (r_tap_idx == IDX_W'(TAP_LEN - 1));

    // Shared multiplier: FILTER feeds the coefficient, UPDATE feeds MU*err; delay tap is the other side.
    assign w_mu_err = OPA_W'(MU) * OPA_W'(r_err);
    assign w_opa    = (r_state == S_FILTER) ? OPA_W'(r_coeff[r_tap_idx]) : w_mu_err;
    assign w_prod   = PRD_W'(w_opa) * PRD_W'(r_delay[r_tap_idx]);

    // y is only needed inside the single ERROR cycle, so it is kept combinational off acc.
    assign w_ys = YS_W'(w_y) * YS_W'(NOISE_SCLE);

`ifdef ANC_SAT_EN
    localparam logic signed [DAT_LEN-1:0]   DMAX = {1'b0, {(DAT_LEN-1){1'b1}}};
    localparam logic signed [DAT_LEN-1:0]   DMIN = {1'b1, {(DAT_LEN-1){1'b0}}};
    localparam logic signed [COEFF_LEN-1:0] CMAX = {1'b0, {(COEFF_LEN-1){1'b1}}};
    localparam logic signed [COEFF_LEN-1:0] CMIN = {1'b1, {(COEFF_LEN-1){1'b0}}};

    function automatic logic signed [DAT_LEN-1:0] f_sat_dat(input logic signed [ACC_W-1:0] v);
        if (v > ACC_W'(DMAX))      return DMAX;
        else if (v < ACC_W'(DMIN)) return DMIN;
        else                       return v[DAT_LEN-1:0];
    endfunction

    function automatic logic signed [COEFF_LEN-1:0] f_sat_coef(input logic signed [64:0] v);
        if (v > 65'(CMAX))      return CMAX;
        else if (v < 65'(CMIN)) return CMIN;
        else                    return v[COEFF_LEN-1:0];
    endfunction

    logic signed [63:0] w_p;
    assign w_p         = 64'(w_prod) >>> 15;
    assign w_y         = f_sat_dat(r_acc >>> 12);
    assign w_err       = f_sat_dat(ACC_W'(r_d_hold) - ACC_W'(w_y));
    assign w_cleaned   = f_sat_dat(ACC_W'(r_d_hold) - ACC_W'(w_ys >>> 15));
    assign w_coeff_new = f_sat_coef(65'(r_coeff[r_tap_idx]) + 65'(w_p));
`else
    assign w_y         = DAT_LEN'(r_acc >>> 12);
    assign w_err       = DAT_LEN'(r_d_hold - w_y);
    assign w_cleaned   = DAT_LEN'(CL_W'(r_d_hold) - CL_W'(w_ys >>> 15));
    assign w_coeff_new = r_coeff[r_tap_idx] + COEFF_LEN'(64'(w_prod) >>> 15);
`endif

    // State register; reset aborts any sample in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = !rst;
                if (in_valid) w_state_nxt = S_FILTER;
            end
            S_FILTER: if (w_last_tap) w_state_nxt = S_ERROR;
            S_ERROR:  w_state_nxt = r_adapt_hold ? S_UPDATE : S_OUT;
            S_UPDATE: if (w_last_tap) w_state_nxt = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: delay shift on accept, tap-serial accumulate, error capture, tap-serial update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAP_LEN; k++) begin
                r_coeff[k] <= '0;
                r_delay[k] <= '0;
            end
            r_acc        <= '0;
            r_err        <= '0;
            r_d_hold     <= '0;
            r_cleaned    <= '0;
            r_adapt_hold <= 1'b0;
            r_tap_idx    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int k = TAP_LEN - 1; k > 0; k--) r_delay[k] <= r_delay[k-1];
                        r_delay[0]   <= noise_in;
                        r_d_hold     <= desired_in;
                        r_adapt_hold <= adapt_en;
                        r_acc        <= '0;
                        r_tap_idx    <= '0;
                    end
                end
                S_FILTER: begin
                    r_acc     <= r_acc + ACC_W'(w_prod);
                    r_tap_idx <= w_last_tap ? '0 : r_tap_idx + IDX_W'(1);
                end
                S_ERROR: begin
                    r_err     <= w_err;
                    r_cleaned <= w_cleaned;
                    r_tap_idx <= '0;
                end
                S_UPDATE: begin
                    r_coeff[r_tap_idx] <= w_coeff_new;
                    r_tap_idx          <= w_last_tap ? '0 : r_tap_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign cleaned_out = r_cleaned;

endmodule

// File: tb/tb_anc_nlms_seq.sv
// Bench for anc_nlms_seq: directed scenarios plus randomized samples, checked
// against a per-sample arithmetic model of the NLMS canceller.
module tb_anc_nlms_seq;
    localparam int T = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, adapt_en = 1'b0, out_ready = 1'b0;
    logic signed [15:0] noise_in = '0, desired_in = '0;
    logic in_ready, out_valid, busy;
    logic signed [15:0] cleaned_out;

    int n_chk = 0;
    int n_err = 0;

    longint m_coeff [T];
    longint m_delay [T];

    anc_nlms_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .noise_in(noise_in), .desired_in(desired_in), .adapt_en(adapt_en),
        .out_valid(out_valid), .out_ready(out_ready), .cleaned_out(cleaned_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrapw(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint satw(input longint v, input int w);
        longint mx, mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
        return (v > mx) ? mx : ((v < mn) ? mn : v);
    endfunction

    function automatic longint fit(input longint v, input int w);
`ifdef ANC_SAT_EN
        return satw(v, w);
`else
        return wrapw(v, w);
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < T; k++) begin
            m_coeff[k] = 0;
            m_delay[k] = 0;
        end
    endtask

    // One whole sample: FIR sum, error, cleaned output, optional NLMS update.
    task automatic model_step(input longint nz, input longint ds, input bit ad, output longint cl);
        longint acc, y, e;
        for (int k = T - 1; k > 0; k--) m_delay[k] = m_delay[k-1];
        m_delay[0] = nz;
        acc = 0;
        for (int k = 0; k < T; k++) acc += m_coeff[k] * m_delay[k];
        y  = fit(acc >>> 12, 16);
        e  = fit(ds - y, 16);
        cl = fit(ds - ((y * 16384) >>> 15), 16);
        if (ad)
            for (int k = 0; k < T; k++)
                m_coeff[k] = fit(m_coeff[k] + ((4096 * e * m_delay[k]) >>> 15), 32);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Push one sample, wait for the result while poking adapt_en/in_valid,
    // optionally stall the sink for `hold` cycles, then complete the handshake.
    task automatic run_sample(input longint nz, input longint ds, input bit ad, input int hold,
                              output int lat, output longint got);
        longint exp_cl;
        longint held;
        int n;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("in_ready_wait", longint'(in_ready), 1);
        noise_in = 16'(nz); desired_in = 16'(ds); adapt_en = ad; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_step(nz, ds, ad, exp_cl);
        lat = 1;
        while (!out_valid && lat < 300) begin
            adapt_en = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) == 0);
            noise_in = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("out_valid_seen", longint'(out_valid), 1);
        got = cleaned_out;
        chk("cleaned", got, exp_cl);
        held = cleaned_out;
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == hold / 2);
            noise_in = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_stable", longint'(cleaned_out), held);
            chk("hold_in_ready", longint'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_hs", longint'(in_ready), 1);
    endtask

    initial begin
        int lat;
        longint got;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_cleaned", longint'(cleaned_out), 0);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("release_in_ready", longint'(in_ready), 1);

        run_sample(500, 1000, 1'b1, 0, lat, got);
        chk("s1_lat", lat, 66);
        chk("s1_clean", got, 1000);
        run_sample(500, 1000, 1'b1, 0, lat, got);
        chk("s2_clean", got, -2814);

        do_reset();
        run_sample(500, 1000, 1'b1, 0, lat, got);
        run_sample(500, -32000, 1'b1, 0, lat, got);
`ifdef ANC_SAT_EN
        chk("s2_boundary", got, -32768);
`else
        chk("s2_boundary", got, 29722);
`endif

        run_sample(300, -700, 1'b0, 0, lat, got);
        chk("noadapt_lat", lat, 34);
        run_sample(-250, 900, 1'b1, 0, lat, got);

        run_sample(1234, -4321, 1'b1, 10, lat, got);
        run_sample(77, 2000, 1'b1, 0, lat, got);

        // Abort a sample partway through the update phase.
        noise_in = 16'sd500; desired_in = 16'sd1000; adapt_en = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        chk("mid_busy", longint'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_in_ready", longint'(in_ready), 0);
        chk("mid_rst_cleaned", longint'(cleaned_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        run_sample(500, 1000, 1'b1, 0, lat, got);
        chk("post_rst_lat", lat, 66);
        chk("post_rst_clean", got, 1000);

        for (int s = 0; s < 25; s++) begin
            longint nz, ds;
            bit ad;
            nz = longint'($urandom_range(0, 8000)) - 4000;
            ds = longint'($urandom_range(0, 40000)) - 20000;
            ad = 1'($urandom_range(0, 1));
            run_sample(nz, ds, ad, int'($urandom_range(0, 3)), lat, got);
            chk("rand_lat", lat, ad ? 66 : 34);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
